// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   CLA_WIDTH / CLA_GRP : default operand width and lookahead group size.
//   CLA_MAX_WIDTH       : widest operand the stage register can carry.
//   cla_nstg()          : pipeline depth, one lookahead group per stage.
//   cla_stage_t         : contents of one inter-stage pipeline register.
package cla_pkg;

  localparam int CLA_WIDTH     = 16;
  localparam int CLA_GRP       = 4;
  localparam int CLA_MAX_WIDTH = 64;

  function automatic int cla_nstg(input int width, input int grp);
    return width / grp;
  endfunction

  // Operand remainders are shifted down one group per stage, so the group
  // being resolved always sits in bits [GRP-1:0]. Completed sum groups are
  // shifted in from the top so they land in place after the last stage.
  // Fields are sized for the widest supported operand; the top level only
  // ever loads the low WIDTH bits.
  typedef struct packed {
    logic                     valid;
    logic [CLA_MAX_WIDTH-1:0] a_rem;
    logic [CLA_MAX_WIDTH-1:0] b_rem;
    logic [CLA_MAX_WIDTH-1:0] sum_done;
    logic                     carry;
    logic                     a_msb;
    logic                     b_msb;
  } cla_stage_t;

endpackage

// File: rtl/cla_group.sv
// Combinational GRP-bit carry-lookahead group.
//   a, b : group operand bits      cin  : carry into the group
//   sum  : group sum bits          cout : carry out of the group
//   gG   : group generate          gP   : group propagate
// Every internal carry is the fully expanded sum of products
// c[i+1] = G[i] | P[i]G[i-1] | ... | P[i..0]cin, not a ripple chain.
module cla_group #(
  parameter int GRP = 4
) (
  input  logic [GRP-1:0] a,
  input  logic [GRP-1:0] b,
  input  logic           cin,
  output logic [GRP-1:0] sum,
  output logic           cout,
  output logic           gG,
  output logic           gP
);

  logic [GRP-1:0] g;
  logic [GRP-1:0] p;
  logic [GRP:0]   c;
  logic           c_term;
  logic           c_acc;
  logic           g_term;
  logic           g_acc;

  assign g = a & b;
  assign p = a | b;

  always_comb begin
    c      = '0;
    c_term = 1'b0;
    c_acc  = 1'b0;
    c[0]   = cin;
    for (int i = 0; i < GRP; i++) begin
      // cin propagated through every bit up to i
      c_term = cin;
      for (int k = 0; k <= i; k++) c_term = c_term & p[k];
      c_acc = c_term;
      // generate at bit j propagated through bits j+1..i
      for (int j = 0; j <= i; j++) begin
        c_term = g[j];
        for (int k = j + 1; k <= i; k++) c_term = c_term & p[k];
        c_acc = c_acc | c_term;
      end
      c[i+1] = c_acc;
    end
    sum  = a ^ b ^ c[GRP-1:0];
    cout = c[GRP];
  end

  // Group-level terms, independent of cin, for a higher lookahead level.
  always_comb begin
    g_term = 1'b0;
    g_acc  = 1'b0;
    for (int j = 0; j < GRP; j++) begin
      g_term = g[j];
      for (int k = j + 1; k < GRP; k++) g_term = g_term & p[k];
      g_acc = g_acc | g_term;
    end
    gG = g_acc;
    gP = &p;
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one GRP-bit group per stage.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand beat handshake
//   in_a, in_b          : operands
//   in_cin              : carry-in (ignored when subtracting)
//   in_sub              : 0 = A+B+cin, 1 = A-B computed as A+~B+1
//   out_valid/out_ready : result handshake
//   out_sum             : {carry_out, sum}; for subtraction carry_out=1 means no borrow
//   out_ovf             : signed two's-complement overflow
// Requires WIDTH a multiple of GRP, WIDTH/GRP >= 2 and WIDTH <= CLA_MAX_WIDTH.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GRP   = CLA_GRP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_ovf
);

  localparam int NSTG = cla_nstg(WIDTH, GRP);
  localparam int MW   = CLA_MAX_WIDTH;

  cla_stage_t     stg_q [NSTG];
  cla_stage_t     stg_d [NSTG];
  logic [GRP-1:0] grp_sum [NSTG];
  logic           grp_cout [NSTG];
  logic           grp_gg [NSTG];
  logic           grp_gp [NSTG];
  logic [WIDTH-1:0] b_eff;
  logic           adv;

  // Handshake: a beat transfers on a cycle where valid && ready are both high.
  // The whole pipe advances together (adv); it freezes only when a result is
  // waiting and downstream is not taking it, so in_ready is simply adv.
  assign adv       = !stg_q[NSTG-1].valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = stg_q[NSTG-1].valid;
  assign b_eff     = in_sub ? ~in_b : in_b;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    cla_group #(.GRP(GRP)) u_grp (
      .a    (stg_q[k].a_rem[GRP-1:0]),
      .b    (stg_q[k].b_rem[GRP-1:0]),
      .cin  (stg_q[k].carry),
      .sum  (grp_sum[k]),
      .cout (grp_cout[k]),
      .gG   (grp_gg[k]),
      .gP   (grp_gp[k])
    );
  end

  // Data fields load only behind a valid beat, so bubbles leave the last
  // result visible on out_sum/out_ovf after it has been consumed.
  always_comb begin
    stg_d = stg_q;
    if (adv) begin
      stg_d[0].valid = in_valid;
      if (in_valid) begin
        stg_d[0].a_rem    = MW'(in_a);
        stg_d[0].b_rem    = MW'(b_eff);
        stg_d[0].sum_done = '0;
        stg_d[0].carry    = in_sub | in_cin;
        stg_d[0].a_msb    = in_a[WIDTH-1];
        stg_d[0].b_msb    = b_eff[WIDTH-1];
      end
      for (int k = 1; k < NSTG; k++) begin
        stg_d[k].valid = stg_q[k-1].valid;
        if (stg_q[k-1].valid) begin
          stg_d[k].a_rem    = stg_q[k-1].a_rem >> GRP;
          stg_d[k].b_rem    = stg_q[k-1].b_rem >> GRP;
          stg_d[k].sum_done = (stg_q[k-1].sum_done >> GRP)
                            | (MW'(grp_sum[k-1]) << (WIDTH - GRP));
          stg_d[k].carry    = grp_cout[k-1];
          stg_d[k].a_msb    = stg_q[k-1].a_msb;
          stg_d[k].b_msb    = stg_q[k-1].b_msb;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) stg_q[k] <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  // The last group resolves combinationally from the final register; earlier
  // groups already sit in sum_done[WIDTH-1:GRP].
  assign out_sum = {grp_cout[NSTG-1], grp_sum[NSTG-1], stg_q[NSTG-1].sum_done[WIDTH-1:GRP]};
  assign out_ovf = (stg_q[NSTG-1].a_msb == stg_q[NSTG-1].b_msb)
                && (grp_sum[NSTG-1][GRP-1] != stg_q[NSTG-1].a_msb);

  // Group generate/propagate must reproduce the group carry-out.
  always_comb begin
    for (int k = 0; k < NSTG; k++)
      assert (grp_cout[k] == (grp_gg[k] | (grp_gp[k] & stg_q[k].carry)));
  end

endmodule
